sort_job_scheduler: RTL and testbench
=====================================

// Module: sort_job_scheduler
// PURPOSE
//  Shares one counting-sort engine (8 x 4-bit keys per job) among NUM_REQ requesters.
//  Round-robin arbitration selects a job and holds its operand stable on the engine input.
//  It drives the engine's start/clear level, waits for valid, and captures the sorted word.
//  It then clears the engine and returns the result to the owner with a done pulse.
//  A watchdog aborts a job if the engine never reports valid.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  TIMEOUT  64  max RUN cycles before abort (engine nominal <= 33)
// PORTS
//  clk_i         in   1          clock, rising edge
//  rst_i         in   1          synchronous, active-high reset (shared with engine)
//  req_i         in   NUM_REQ    request level per requester
//  nums_i        in   NUM_REQ*32 operand of requester k at [32k+31:32k]
//  grant_o       out  NUM_REQ    one-hot, 1-cycle pulse: operand captured
//  done_o        out  NUM_REQ    one-hot, 1-cycle pulse: result_o/error_o valid
//  result_o      out  32         sorted word, held until next RESP
//  error_o       out  1          1 = job aborted by watchdog; valid with done_o
//  busy_o        out  1          1 in any state except IDLE
//  sort_start_o  out  1          engine start_clear (1 = run/hold, 0 = clear)
//  sort_nums_o   out  32         engine operand (registered)
//  sort_valid_i  in   1          engine valid
//  sort_nums_i   in   32         engine sorted output
// BEHAVIOUR
//  Reset: all outputs 0. state=IDLE, rr_ptr=0, timer=0, owner=0. Engine is reset by the same rst_i.
//  Reset mid-job: job is dropped; no done_o is issued; requester must re-request.
//  Arbitration:
//   - Evaluated only in IDLE.
//   - Winner is the first k with req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  IDLE:
//   - Any req: register sort_nums_o <= nums_i[winner], owner <= winner, grant_o[winner] <= 1,
//     sort_start_o <= 1, timer <= 0, go RUN.
//   - No req: stay. sort_valid_i is ignored.
//  Requester rules:
//   - Drop req_i in the cycle after grant_o.
//   - Do not re-assert until done_o.
//   - Keep nums_i don't-care after grant.
//  RUN: sort_start_o=1, sort_nums_o stable, timer++ each cycle.
//   - sort_valid_i=1: result_o <= sort_nums_i, error_o <= 0, go CLEAR.
//   - Else if timer==TIMEOUT-1: result_o <= 0, error_o <= 1, go CLEAR.
//   - Valid and timeout in the same cycle: valid wins, no error.
//  CLEAR: sort_start_o=0 for exactly 2 cycles.
//   - The engine sees the low level and returns to its idle state.
//   - Then go RESP.
//  RESP:
//   - done_o[owner]=1 for 1 cycle; result_o/error_o are valid this cycle.
//   - rr_ptr <= (owner+1) mod NUM_REQ; go IDLE.
//  Back-to-back: next grant no earlier than the IDLE cycle after RESP, so at least 1 IDLE cycle between jobs.
//  Widths:
//   - timer is $clog2(TIMEOUT+1) bits and saturates.
//   - rr_ptr/owner are $clog2(NUM_REQ) bits; wrap is explicit mod NUM_REQ.
//  Latency (req to done): 1 + RUN(engine latency) + 2 + 1 cycles; never > TIMEOUT+4.
//  sort_start_o never toggles except IDLE->RUN (rise) and RUN->CLEAR (fall).
// TESTING (with real engine; lane0 = bits[3:0] = smallest)
//  1. req_i=0001, nums_i[31:0]=0x3A1F0C52 -> grant_o=0001 once; done_o=0001;
//     result_o=0xFCA53210; error_o=0.
//  2. req_i=1111 same cycle from reset, distinct operands -> grants/dones in order 0,1,2,3;
//     each result correct; busy_o low exactly 1 cycle between jobs.
//  3. req0 re-requests after each done while req2 held -> service order 0,2,0,2,...;
//     rr_ptr wraps 3->0 when NUM_REQ=4 and owner=3.
//  4. Engine model never raises valid -> sort_start_o falls after TIMEOUT RUN cycles;
//     done_o=owner with error_o=1, result_o=0; next job then completes normally.
//  5. rst_i pulsed 10 cycles into RUN -> next cycle all outputs 0, no done_o;
//     fresh req0 then completes normally.
//  6. sort_valid_i forced 1 in IDLE -> ignored. valid arriving at timer==TIMEOUT-1 -> error_o=0.

Source files
------------

// File: rtl/sort_job_scheduler.sv
// Round-robin front end that shares one counting-sort engine among NUM_REQ requesters.
// A job is started, the engine is cleared, and the result is returned with a done pulse; a watchdog aborts stalled jobs.
module sort_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*32-1:0]  nums_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [31:0]            result_o,
    output logic                   error_o,
    output logic                   busy_o,
    output logic                   sort_start_o,
    output logic [31:0]            sort_nums_o,
    input  logic                   sort_valid_i,
    input  logic [31:0]            sort_nums_i
);

    localparam int          PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam int unsigned NREQ_U     = NUM_REQ;
    localparam logic [PW-1:0] LAST_REQ   = PW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_owner;
    logic [TW-1:0]      r_timer;
    logic               r_clr_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [31:0]        r_result;
    logic               r_error;
    logic               r_start;
    logic [31:0]        r_sort_nums;

    logic               w_req_any;
    logic [PW-1:0]      w_winner;
    logic [PW-1:0]      w_scan;
    logic [31:0]        w_win_nums;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned ofs);
        int unsigned sum;
        sum = (32'(base) + ofs) % NREQ_U;
        return PW'(sum);
    endfunction

    // Rotating-priority scan: first requester at or after r_rr_ptr wins.
    always_comb begin
        w_req_any = 1'b0;
        w_winner  = '0;
        w_scan    = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            w_scan = wrap_add(r_rr_ptr, i);
            if (!w_req_any && req_i[w_scan]) begin
                w_req_any = 1'b1;
                w_winner  = w_scan;
            end
        end
    end

    always_comb begin
        w_win_nums = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (PW'(i) == w_winner) begin
                w_win_nums = nums_i[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_timer     <= '0;
            r_clr_cnt   <= 1'b0;
            r_grant     <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_start     <= 1'b0;
            r_sort_nums <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_sort_nums       <= w_win_nums;
                        r_owner           <= w_winner;
                        r_grant[w_winner] <= 1'b1;
                        r_start           <= 1'b1;
                        r_timer           <= '0;
                        r_state           <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_timer != TIMER_SAT) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // Valid is checked first so a result on the last allowed cycle is not aborted.
                    if (sort_valid_i) begin
                        r_result  <= sort_nums_i;
                        r_error   <= 1'b0;
                        r_start   <= 1'b0;
                        r_clr_cnt <= 1'b0;
                        r_state   <= S_CLEAR;
                    end else if (r_timer == TIMER_LAST) begin
                        r_result  <= '0;
                        r_error   <= 1'b1;
                        r_start   <= 1'b0;
                        r_clr_cnt <= 1'b0;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt) begin
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_RESP;
                    end else begin
                        r_clr_cnt <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= (r_owner == LAST_REQ) ? '0 : r_owner + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_o      = r_grant;
    assign done_o       = r_done;
    assign result_o     = r_result;
    assign error_o      = r_error;
    assign busy_o       = (r_state != S_IDLE);
    assign sort_start_o = r_start;
    assign sort_nums_o  = r_sort_nums;

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Directed bench for sort_job_scheduler with a behavioural counting-sort engine of programmable latency.
// Expected sorted words are hand-computed constants.
module tb_sort_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] nums;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic [31:0]  result;
    logic         error;
    logic         busy;
    logic         sort_start;
    logic [31:0]  sort_nums_w;
    logic         sort_valid;
    logic [31:0]  eng_nums;
    logic         eng_valid;
    logic         force_valid;
    int           eng_lat;
    int           eng_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sort_job_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .nums_i       (nums),
        .grant_o      (grant),
        .done_o       (done),
        .result_o     (result),
        .error_o      (error),
        .busy_o       (busy),
        .sort_start_o (sort_start),
        .sort_nums_o  (sort_nums_w),
        .sort_valid_i (sort_valid),
        .sort_nums_i  (eng_nums)
    );

    function automatic logic [31:0] sort_word(input logic [31:0] w);
        int unsigned cnt [16];
        int unsigned p;
        logic [31:0] r;
        for (int v = 0; v < 16; v++) cnt[v] = 0;
        for (int i = 0; i < 8; i++) cnt[w[4*i +: 4]]++;
        r = '0;
        p = 0;
        for (int v = 0; v < 16; v++) begin
            for (int unsigned c = 0; c < cnt[v]; c++) begin
                r[4*p +: 4] = 4'(v);
                p++;
            end
        end
        return r;
    endfunction

    // Engine: counts while start is high, raises valid after eng_lat+1 cycles, clears when start is low.
    always @(posedge clk) begin
        if (rst || !sort_start) begin
            eng_cnt   <= 0;
            eng_valid <= 1'b0;
            eng_nums  <= '0;
        end else if (eng_cnt == eng_lat) begin
            eng_valid <= 1'b1;
            eng_nums  <= sort_word(sort_nums_w);
        end else begin
            eng_cnt <= eng_cnt + 1;
        end
    end

    assign sort_valid = eng_valid | force_valid;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cyc++;
            if (grant !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok, output int cyc, output int n_grant);
        ok      = 1'b0;
        cyc     = 0;
        n_grant = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            cyc++;
            if (grant !== 4'b0000) n_grant++;
            if (done !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_run(output int n);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (sort_start === 1'b1) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; nums = '0; force_valid = 1'b0; eng_lat = 10;
        step(); step(); step();
        n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL rst_grant: got %b want 0000", grant); end
        n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL rst_done: got %b want 0000", done); end
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL rst_error: got %b want 0", error); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (sort_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", sort_start); end
        n_vec++; if (sort_nums_w !== 32'h0) begin n_err++; $display("FAIL rst_sort_nums: got %h want 0", sort_nums_w); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit ok;
        int g, d, ng;
        nums = '0; nums[31:0] = 32'h3A1F0C52; req = 4'b0001;
        wait_grant(ok, g);
        n_vec++; if (!ok || grant !== 4'b0001) begin n_err++; $display("FAIL t1_grant: got %b want 0001", grant); end
        n_vec++; if (sort_nums_w !== 32'h3A1F0C52) begin n_err++; $display("FAIL t1_sort_nums: got %h want 3a1f0c52", sort_nums_w); end
        n_vec++; if (sort_start !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL t1_run: got start=%b busy=%b want 1 1", sort_start, busy); end
        req = 4'b0000;
        wait_done(ok, d, ng);
        n_vec++; if (!ok || done !== 4'b0001) begin n_err++; $display("FAIL t1_done: got %b want 0001", done); end
        n_vec++; if (result !== 32'hFCA53210) begin n_err++; $display("FAIL t1_result: got %h want fca53210", result); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL t1_error: got %b want 0", error); end
        n_vec++; if (ng !== 0) begin n_err++; $display("FAIL t1_extra_grant: got %0d want 0", ng); end
        n_vec++; if (g + d !== 15) begin n_err++; $display("FAIL t1_latency: got %0d want 15", g + d); end
        step();
        n_vec++; if (done !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t1_idle: got done=%b busy=%b want 0000 0", done, busy); end
    endtask

    task automatic test_rr_all();
        bit ok;
        int g, d, ng;
        logic [31:0] exp_r [4];
        logic [3:0]  exp_oh;
        exp_r[0] = 32'h87654321; exp_r[1] = 32'hFFFF0000;
        exp_r[2] = 32'hFEDC3210; exp_r[3] = 32'hECA97421;
        rst = 1'b1; req = '0;
        step(); step();
        nums = {32'h7C4A9E21, 32'h0F1E2D3C, 32'hFFFF0000, 32'h12345678};
        rst = 1'b0; req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            exp_oh = 4'b0001 << j;
            wait_grant(ok, g);
            n_vec++; if (!ok || grant !== exp_oh || g !== 1) begin n_err++; $display("FAIL t2_grant%0d: got %b after %0d want %b after 1", j, grant, g, exp_oh); end
            req[j] = 1'b0;
            wait_done(ok, d, ng);
            n_vec++; if (!ok || done !== exp_oh) begin n_err++; $display("FAIL t2_done%0d: got %b want %b", j, done, exp_oh); end
            n_vec++; if (result !== exp_r[j] || error !== 1'b0) begin n_err++; $display("FAIL t2_result%0d: got %h/%b want %h/0", j, result, error, exp_r[j]); end
            step();
            n_vec++; if (busy !== 1'b0 || grant !== 4'b0) begin n_err++; $display("FAIL t2_gap%0d: got busy=%b grant=%b want 0 0000", j, busy, grant); end
        end
    endtask

    task automatic test_rr_fair();
        bit ok;
        int g, d, ng;
        int order [5];
        logic [3:0]  exp_oh;
        logic [31:0] exp_res;
        order[0] = 0; order[1] = 2; order[2] = 0; order[3] = 2; order[4] = 0;
        nums = '0; nums[31:0] = 32'h99999999; nums[95:64] = 32'h00000001;
        req = 4'b0101;
        for (int j = 0; j < 5; j++) begin
            exp_oh  = 4'b0001 << order[j];
            exp_res = (order[j] == 0) ? 32'h99999999 : 32'h10000000;
            wait_grant(ok, g);
            n_vec++; if (!ok || grant !== exp_oh) begin n_err++; $display("FAIL t3_grant%0d: got %b want %b", j, grant, exp_oh); end
            req[order[j]] = 1'b0;
            wait_done(ok, d, ng);
            n_vec++; if (!ok || done !== exp_oh || result !== exp_res) begin n_err++; $display("FAIL t3_done%0d: got %b/%h want %b/%h", j, done, result, exp_oh, exp_res); end
            if (j < 4) req[order[j]] = 1'b1;
            else req = 4'b0000;
        end
        step();
    endtask

    task automatic test_timeout();
        bit ok;
        int g, d, ng, n;
        eng_lat = 100000;
        nums = '0; nums[63:32] = 32'h3A1F0C52; req = 4'b0010;
        wait_grant(ok, g);
        n_vec++; if (!ok || grant !== 4'b0010) begin n_err++; $display("FAIL t4_grant: got %b want 0010", grant); end
        req = 4'b0000;
        count_run(n);
        n_vec++; if (n !== TIMEOUT) begin n_err++; $display("FAIL t4_run_cycles: got %0d want %0d", n, TIMEOUT); end
        wait_done(ok, d, ng);
        n_vec++; if (!ok || done !== 4'b0010) begin n_err++; $display("FAIL t4_done: got %b want 0010", done); end
        n_vec++; if (error !== 1'b1 || result !== 32'h0) begin n_err++; $display("FAIL t4_abort: got %b/%h want 1/00000000", error, result); end
        step();
        eng_lat = 10;
        nums[127:96] = 32'h0F1E2D3C; req = 4'b1000;
        wait_grant(ok, g);
        n_vec++; if (!ok || grant !== 4'b1000) begin n_err++; $display("FAIL t4_next_grant: got %b want 1000", grant); end
        req = 4'b0000;
        wait_done(ok, d, ng);
        n_vec++; if (!ok || done !== 4'b1000 || result !== 32'hFEDC3210 || error !== 1'b0) begin n_err++; $display("FAIL t4_next_done: got %b/%h/%b want 1000/fedc3210/0", done, result, error); end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int g, d, ng, n_done, n_busy;
        eng_lat = 20;
        nums = '0; nums[31:0] = 32'h3A1F0C52; req = 4'b0001;
        wait_grant(ok, g);
        n_vec++; if (!ok || grant !== 4'b0001) begin n_err++; $display("FAIL t5_grant: got %b want 0001", grant); end
        req = 4'b0000;
        repeat (10) step();
        rst = 1'b1;
        step();
        n_vec++; if ({grant, done, busy, sort_start, error} !== 11'b0) begin n_err++; $display("FAIL t5_ctrl_zero: got g=%b d=%b b=%b s=%b e=%b want all 0", grant, done, busy, sort_start, error); end
        n_vec++; if (result !== 32'h0 || sort_nums_w !== 32'h0) begin n_err++; $display("FAIL t5_data_zero: got %h/%h want 0/0", result, sort_nums_w); end
        rst = 1'b0;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done !== 4'b0) n_done++;
            if (busy !== 1'b0) n_busy++;
        end
        n_vec++; if (n_done !== 0 || n_busy !== 0) begin n_err++; $display("FAIL t5_dropped: got done_cycles=%0d busy_cycles=%0d want 0 0", n_done, n_busy); end
        eng_lat = 10;
        nums[31:0] = 32'h12345678; req = 4'b0001;
        wait_grant(ok, g);
        req = 4'b0000;
        wait_done(ok, d, ng);
        n_vec++; if (!ok || done !== 4'b0001 || result !== 32'h87654321 || error !== 1'b0) begin n_err++; $display("FAIL t5_fresh: got %b/%h/%b want 0001/87654321/0", done, result, error); end
        step();
    endtask

    task automatic test_valid_edge();
        bit ok;
        int g, d, ng, n, n_act;
        force_valid = 1'b1; req = 4'b0000;
        n_act = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0 || sort_start !== 1'b0 || done !== 4'b0) n_act++;
        end
        n_vec++; if (n_act !== 0) begin n_err++; $display("FAIL t6_idle_valid: got %0d active cycles want 0", n_act); end
        n_vec++; if (result !== 32'h87654321) begin n_err++; $display("FAIL t6_idle_result: got %h want 87654321", result); end
        force_valid = 1'b0;
        eng_lat = TIMEOUT - 2;
        nums = '0; nums[63:32] = 32'h7C4A9E21; req = 4'b0010;
        wait_grant(ok, g);
        n_vec++; if (!ok || grant !== 4'b0010) begin n_err++; $display("FAIL t6_grant: got %b want 0010", grant); end
        req = 4'b0000;
        count_run(n);
        n_vec++; if (n !== TIMEOUT) begin n_err++; $display("FAIL t6_run_cycles: got %0d want %0d", n, TIMEOUT); end
        wait_done(ok, d, ng);
        n_vec++; if (!ok || done !== 4'b0010) begin n_err++; $display("FAIL t6_done: got %b want 0010", done); end
        n_vec++; if (error !== 1'b0 || result !== 32'hECA97421) begin n_err++; $display("FAIL t6_late_valid: got %b/%h want 0/eca97421", error, result); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_all();
        test_rr_fair();
        test_timeout();
        test_reset_mid();
        test_valid_edge();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_watchdog: got no finish want finish before 500000");
        $fatal(1);
    end

endmodule
